alaw_expand_sched: RTL and testbench

Round-robin scheduler that shares one A-law expander datapath between NUM_CH compressed-sample requesters. Each requester is served through a valid/ready handshake. The block drives the expander input and tracks its fixed pipeline latency with a channel-tag shift register. It captures each result into an output FIFO, tagged with its source channel. Credit accounting prevents FIFO overflow under res_ready backpressure.

---
 rtl/alaw_pkg.sv | 21 ++
 rtl/alaw_expand_sched_if.sv | 37 +++
 rtl/alaw_sched_fifo.sv | 69 ++++++
 rtl/alaw_expand_sched.sv | 136 +++++++++++++
 tb/tb_alaw_expand_sched.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/alaw_pkg.sv
// -----------------------------------------------------------------------------
// alaw_pkg
// Shared constants, sample types and helpers for the A-law expander scheduler.
//   ALAW_CW / ALAW_EW : compressed / expanded sample widths
//   alaw_comp_t       : one compressed sample
//   alaw_exp_t        : one expanded sample
//   ch_w(n)           : bits needed to name one of n channels (never below 1)
// -----------------------------------------------------------------------------
package alaw_pkg;

  localparam int ALAW_CW = 15;
  localparam int ALAW_EW = 24;

  typedef logic [ALAW_CW-1:0] alaw_comp_t;
  typedef logic [ALAW_EW-1:0] alaw_exp_t;

  function automatic int ch_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/alaw_expand_sched_if.sv
// -----------------------------------------------------------------------------
// alaw_expand_sched_if
// Requester and result handshakes of the expander scheduler.
//   req_valid[NUM_CH]      requester -> scheduler, per-channel valid
//   req_data[NUM_CH*CW]    requester -> scheduler, channel i at [i*CW +: CW]
//   req_ready[NUM_CH]      scheduler -> requester, one-hot grant
//   res_valid/res_data/res_ch  scheduler -> consumer, FIFO head
//   res_ready              consumer -> scheduler
// Modports: master = requester/consumer side, slave = scheduler side.
// -----------------------------------------------------------------------------
interface alaw_expand_sched_if
  import alaw_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CW     = ALAW_CW,
  parameter int EW     = ALAW_EW
) ();

  logic [NUM_CH-1:0]       req_valid;
  logic [NUM_CH*CW-1:0]    req_data;
  logic [NUM_CH-1:0]       req_ready;
  logic                    res_valid;
  logic [EW-1:0]           res_data;
  logic [ch_w(NUM_CH)-1:0] res_ch;
  logic                    res_ready;

  modport master (
    output req_valid, req_data, res_ready,
    input  req_ready, res_valid, res_data, res_ch
  );

  modport slave (
    input  req_valid, req_data, res_ready,
    output req_ready, res_valid, res_data, res_ch
  );

endinterface

// File: rtl/alaw_sched_fifo.sv
// -----------------------------------------------------------------------------
// alaw_sched_fifo
// Small synchronous FIFO holding {ch, data} results. The head comes straight
// from storage flops, so rd_data/rd_valid have no combinational input path.
//   clk, rst_n        clock, asynchronous active-low reset
//   wr_en, wr_data    push (ignored when full and not popping)
//   rd_en             pop (ignored when empty)
//   rd_valid, rd_data head entry
//   count             current occupancy
// -----------------------------------------------------------------------------
module alaw_sched_fifo #(
  parameter int DEPTH = 3,
  parameter int W     = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_en,
  input  logic [W-1:0]               wr_data,
  input  logic                       rd_en,
  output logic                       rd_valid,
  output logic [W-1:0]               rd_data,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNTW = $clog2(DEPTH + 1);

  logic [W-1:0]     mem_reg [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [CNTW-1:0]  count_reg;
  logic             do_wr;
  logic             do_rd;
  logic [DEPTH-1:0] wr_sel;

  assign do_rd = rd_en && (count_reg != '0);
  // A pop frees the slot in the same edge, so full-with-pop still accepts.
  assign do_wr = wr_en && ((count_reg != CNTW'(DEPTH)) || do_rd);

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wsel
    assign wr_sel[gi] = do_wr && (wr_ptr_reg == AW'(gi));
  end

  // Depth need not be a power of two, so pointers wrap explicitly.
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_reg[i] <= '0;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_sel[i]) mem_reg[i] <= wr_data;
      end
      if (do_wr) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      if (do_rd) rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      count_reg <= count_reg + CNTW'(do_wr) - CNTW'(do_rd);
    end
  end

  assign rd_valid = (count_reg != '0);
  assign rd_data  = mem_reg[rd_ptr_reg];
  assign count    = count_reg;

endmodule

// File: rtl/alaw_expand_sched.sv
// -----------------------------------------------------------------------------
// alaw_expand_sched
// Round-robin scheduler sharing one A-law expander between NUM_CH requesters.
// The granted sample is registered onto exp_compressed, its channel tag rides
// a EXP_LAT+1 deep tag pipe, and the expander result is captured into a
// channel-tagged output FIFO. Credit (tags in flight + FIFO occupancy) is
// bounded by FIFO_DEPTH so the FIFO can never overflow under backpressure.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   bus (slave)     req_valid/req_data/req_ready, res_valid/res_data/res_ch/res_ready
//   exp_compressed  registered expander input
//   exp_expanded    expander output, valid EXP_LAT edges after its input
//   stall_cnt, grant_cnt  only with ALAW_SCHED_STATS_EN defined: saturating
//                   counts of credit-stalled cycles and of grants
// -----------------------------------------------------------------------------
module alaw_expand_sched
  import alaw_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int CW         = ALAW_CW,
  parameter int EW         = ALAW_EW,
  parameter int EXP_LAT    = 1,
  parameter int FIFO_DEPTH = EXP_LAT + 2
) (
  input  logic               clk,
  input  logic               rst_n,
  alaw_expand_sched_if.slave bus,
  output logic [CW-1:0]      exp_compressed,
  input  logic [EW-1:0]      exp_expanded
`ifdef ALAW_SCHED_STATS_EN
  ,
  output logic [15:0]        stall_cnt,
  output logic [15:0]        grant_cnt
`endif
);

  localparam int CHW = ch_w(NUM_CH);
  localparam int CRW = $clog2(FIFO_DEPTH + 1);

  typedef struct packed {
    logic           valid;
    logic [CHW-1:0] ch;
  } tag_t;

  logic [CHW-1:0]       ptr_reg;
  logic [CRW-1:0]       credit_reg;
  logic [CW-1:0]        exp_comp_reg;
  tag_t [EXP_LAT:0]     tag_pipe_reg;

  logic                 pop;
  logic                 credit_ok;
  logic                 grant;
  logic [CHW-1:0]       winner;
  logic [NUM_CH-1:0]    grant_vec;
  logic [CRW-1:0]       fifo_count;

  assign pop = bus.res_valid && bus.res_ready;
  // Gating with rst_n keeps req_ready low for the whole reset window.
  assign credit_ok = rst_n && ((credit_reg - CRW'(pop)) < CRW'(FIFO_DEPTH));

  // First valid channel at or after the pointer, wrapping.
  always_comb begin
    grant     = 1'b0;
    winner    = '0;
    grant_vec = '0;
    for (int off = 0; off < NUM_CH; off++) begin
      if (credit_ok && !grant && bus.req_valid[(int'(ptr_reg) + off) % NUM_CH]) begin
        grant  = 1'b1;
        winner = CHW'((int'(ptr_reg) + off) % NUM_CH);
      end
    end
    if (grant) grant_vec[winner] = 1'b1;
  end

  assign bus.req_ready = grant_vec;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_reg      <= '0;
      credit_reg   <= '0;
      exp_comp_reg <= '0;
      tag_pipe_reg <= '0;
    end else begin
      if (grant) begin
        exp_comp_reg <= bus.req_data[int'(winner)*CW +: CW];
        ptr_reg      <= (winner == CHW'(NUM_CH - 1)) ? '0 : winner + 1'b1;
      end
      // Idle cycles push an invalid tag so stage EXP_LAT lines up with the
      // expander output for every issue slot.
      tag_pipe_reg <= {tag_pipe_reg[EXP_LAT-1:0], tag_t'{valid: grant, ch: winner}};
      credit_reg   <= credit_reg + CRW'(grant) - CRW'(pop);
    end
  end

  assign exp_compressed = exp_comp_reg;

  alaw_sched_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (CHW + EW)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (tag_pipe_reg[EXP_LAT].valid),
    .wr_data  ({tag_pipe_reg[EXP_LAT].ch, exp_expanded}),
    .rd_en    (bus.res_ready),
    .rd_valid (bus.res_valid),
    .rd_data  ({bus.res_ch, bus.res_data}),
    .count    (fifo_count)
  );

  // Credit counts FIFO entries plus in-flight tags, so it bounds occupancy.
  assert property (@(posedge clk) disable iff (!rst_n) fifo_count <= credit_reg);

`ifdef ALAW_SCHED_STATS_EN
  logic [15:0] stall_cnt_reg;
  logic [15:0] grant_cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_reg <= '0;
      grant_cnt_reg <= '0;
    end else begin
      // With credit available some valid channel always wins, so a stall
      // is exactly "someone asks, credit says no".
      if ((|bus.req_valid) && !credit_ok && (stall_cnt_reg != 16'hFFFF))
        stall_cnt_reg <= stall_cnt_reg + 16'd1;
      if (grant && (grant_cnt_reg != 16'hFFFF))
        grant_cnt_reg <= grant_cnt_reg + 16'd1;
    end
  end

  assign stall_cnt = stall_cnt_reg;
  assign grant_cnt = grant_cnt_reg;
`endif

endmodule

// File: tb/tb_alaw_expand_sched.sv
// -----------------------------------------------------------------------------
// tb_alaw_expand_sched
// Bench for alaw_expand_sched with a 1-cycle stand-in expander. Builds with or
// without ALAW_SCHED_STATS_EN.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_alaw_expand_sched;
  import alaw_pkg::*;

  localparam int NCH   = 4;
  localparam int CWL   = ALAW_CW;
  localparam int EWL   = ALAW_EW;
  localparam int LAT   = 1;
  localparam int DEPTH = LAT + 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  alaw_expand_sched_if #(.NUM_CH(NCH), .CW(CWL), .EW(EWL)) bus ();
  alaw_comp_t exp_compressed;
  alaw_exp_t  exp_expanded;
`ifdef ALAW_SCHED_STATS_EN
  logic [15:0] stall_cnt;
  logic [15:0] grant_cnt;
`endif

  alaw_expand_sched #(
    .NUM_CH(NCH), .CW(CWL), .EW(EWL), .EXP_LAT(LAT), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .bus            (bus),
    .exp_compressed (exp_compressed),
    .exp_expanded   (exp_expanded)
`ifdef ALAW_SCHED_STATS_EN
    ,
    .stall_cnt      (stall_cnt),
    .grant_cnt      (grant_cnt)
`endif
  );

  // Stand-in expander: signed offset-and-scale, out = 32*x +/- 384.
  // Hits the reference points 0005 -> 000220 and 7FFB -> FFFDE0.
  function automatic logic [23:0] expand(input logic [14:0] c);
    int v;
    v = int'($signed(c));
    if (v < 0) return 24'(v * 32 - 384);
    return 24'(v * 32 + 384);
  endfunction

  always @(posedge clk) exp_expanded <= expand(exp_compressed);

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: outstanding samples in a queue, each stamped with the
  // cycle from which it may appear at the output. Credit is the queue size.
  // ---------------------------------------------------------------------------
  typedef struct {
    int          ch;
    logic [23:0] data;
    int          vis;
  } item_t;

  item_t          sb_q[$];
  int             rr_ptr = 0;
  int             cyc = 0;
  logic [NCH-1:0] m_rdy;
  int             m_win;
  bit             m_vis;
  bit             m_pop;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst_n) begin
      sb_q.delete();
      rr_ptr = 0;
      chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
      chk("rst_res_valid", 64'(bus.res_valid), 64'd0);
    end else begin
      m_vis = (sb_q.size() > 0) && (cyc >= sb_q[0].vis);
      m_pop = m_vis && bus.res_ready;
      m_rdy = '0;
      m_win = -1;
      if (sb_q.size() - int'(m_pop) < DEPTH) begin
        for (int off = 0; off < NCH; off++) begin
          if (m_win < 0 && bus.req_valid[(rr_ptr + off) % NCH]) m_win = (rr_ptr + off) % NCH;
        end
      end
      if (m_win >= 0) m_rdy[m_win] = 1'b1;
      chk("req_ready", 64'(bus.req_ready), 64'(m_rdy));
      chk("res_valid", 64'(bus.res_valid), 64'(m_vis));
      if (m_vis) begin
        chk("res_data", 64'(bus.res_data), 64'(sb_q[0].data));
        chk("res_ch", 64'(bus.res_ch), 64'(sb_q[0].ch));
      end
      if (m_pop) void'(sb_q.pop_front());
      if (m_win >= 0) begin
        // Handshake on the next edge, result LAT+1 edges after that.
        sb_q.push_back('{ch: m_win, data: expand(bus.req_data[m_win*CWL +: CWL]), vis: cyc + LAT + 2});
        rr_ptr = (m_win + 1) % NCH;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int ch, input logic v, input logic [14:0] d);
    bus.req_valid[ch]           = v;
    bus.req_data[ch*CWL +: CWL] = d;
  endtask

  task automatic drain();
    bus.req_valid = '0;
    bus.res_ready = 1'b1;
    repeat (6) tick();
  endtask

  task automatic all_valid_fixed();
    for (int i = 0; i < NCH; i++) set_ch(i, 1'b1, 15'(i + 16));
  endtask

  // One isolated request: handshake on edge k, result visible after k+2.
  task automatic send_one(input string tag, input int ch, input logic [14:0] d,
                          input logic [23:0] e);
    drain();
    set_ch(ch, 1'b1, d);
    @(negedge clk);
    chk({tag, "_grant"}, 64'(bus.req_ready), 64'(1) << ch);
    tick();
    bus.req_valid = '0;
    chk({tag, "_lat0"}, 64'(bus.res_valid), 64'd0);
    tick();
    chk({tag, "_lat1"}, 64'(bus.res_valid), 64'd0);
    tick();
    chk({tag, "_lat2"}, 64'(bus.res_valid), 64'd1);
    chk({tag, "_data"}, 64'(bus.res_data), 64'(e));
    chk({tag, "_ch"}, 64'(bus.res_ch), 64'(ch));
  endtask

  typedef struct {
    int          ch;
    logic [14:0] smp;
    logic [23:0] res;
  } vec_t;

  vec_t vecs[6];
  int   p0;
  int   hs;

  initial begin
    vecs[0] = '{ch: 0, smp: 15'h0005, res: 24'h000220};
    vecs[1] = '{ch: 2, smp: 15'h7FFB, res: 24'hFFFDE0};
    vecs[2] = '{ch: 1, smp: 15'h0000, res: 24'h000180};
    vecs[3] = '{ch: 3, smp: 15'h3FFF, res: 24'h080160};
    vecs[4] = '{ch: 3, smp: 15'h4000, res: 24'hF7FE80};
    vecs[5] = '{ch: 1, smp: 15'h7FFF, res: 24'hFFFE60};

    rst_n         = 1'b0;
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.res_ready = 1'b1;

    // Reset state
    repeat (3) tick();
    chk("reset_req_ready", 64'(bus.req_ready), 64'd0);
    chk("reset_res_valid", 64'(bus.res_valid), 64'd0);
    chk("reset_res_data", 64'(bus.res_data), 64'd0);
    chk("reset_res_ch", 64'(bus.res_ch), 64'd0);
    chk("reset_exp_comp", 64'(exp_compressed), 64'd0);
    rst_n = 1'b1;

    // Table-driven single samples
    for (int i = 0; i < 6; i++) send_one($sformatf("vec%0d", i), vecs[i].ch, vecs[i].smp, vecs[i].res);

    // Fairness: all channels valid, results in rotating order with no gaps
    drain();
    p0 = rr_ptr;
    all_valid_fixed();
    repeat (3) @(posedge clk);
    for (int j = 0; j < 12; j++) begin
      @(negedge clk);
      chk($sformatf("fair_valid%0d", j), 64'(bus.res_valid), 64'd1);
      chk($sformatf("fair_ch%0d", j), 64'(bus.res_ch), 64'((p0 + j) % NCH));
      chk($sformatf("fair_data%0d", j), 64'(bus.res_data), 64'(expand(15'(((p0 + j) % NCH) + 16))));
    end

    // Backpressure: exactly DEPTH handshakes, head held, grant on first pop
    drain();
    p0 = rr_ptr;
    bus.res_ready = 1'b0;
    all_valid_fixed();
    hs = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.req_ready != '0) hs++;
      if (i >= 3) begin
        chk($sformatf("bp_hold_ch%0d", i), 64'(bus.res_ch), 64'(p0));
        chk($sformatf("bp_hold_data%0d", i), 64'(bus.res_data), 64'(expand(15'(p0 + 16))));
      end
      if (i < 7) tick();
    end
    chk("bp_handshakes", 64'(hs), 64'(DEPTH));
    chk("bp_ready_low", 64'(bus.req_ready), 64'd0);
    tick();
    bus.res_ready = 1'b1;
    @(negedge clk);
    chk("bp_resume", 64'(|bus.req_ready), 64'd1);
    repeat (6) tick();

    // Sparse/wrap: pointer at 3, only ch1 and ch3 valid
    send_one("ptr3", 2, 15'h0011, expand(15'h0011));
    drain();
    set_ch(1, 1'b1, 15'h0101);
    set_ch(3, 1'b1, 15'h0303);
    @(negedge clk);
    chk("wrap_g0", 64'(bus.req_ready), 64'b1000);
    tick();
    @(negedge clk);
    chk("wrap_g1", 64'(bus.req_ready), 64'b0010);
    tick();
    @(negedge clk);
    chk("wrap_g2", 64'(bus.req_ready), 64'b1000);
    tick();

    // Reset mid-stream: FIFO holds one, two tags in flight
    drain();
    bus.res_ready = 1'b0;
    all_valid_fixed();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mrst_req_ready", 64'(bus.req_ready), 64'd0);
    chk("mrst_res_valid", 64'(bus.res_valid), 64'd0);
    chk("mrst_res_data", 64'(bus.res_data), 64'd0);
    chk("mrst_res_ch", 64'(bus.res_ch), 64'd0);
    chk("mrst_exp_comp", 64'(exp_compressed), 64'd0);
    bus.req_valid = '0;
    bus.res_ready = 1'b1;
    repeat (2) tick();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk($sformatf("no_stale%0d", i), 64'(bus.res_valid), 64'd0);
    end
    send_one("post_rst", 1, 15'h0005, 24'h000220);

    // Randomized traffic with random backpressure
    for (int n = 0; n < 400; n++) begin
      tick();
      bus.req_valid = NCH'($urandom);
      for (int i = 0; i < NCH; i++) bus.req_data[i*CWL +: CWL] = CWL'($urandom);
      bus.res_ready = ($urandom_range(0, 3) != 0);
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
